// File: rtl/exc_redirect_ctrl.sv
// Redirect sequencer for committed exceptions/ERET: staged flush, bus drain,
// then a single fetch redirect to the latched handler or EPC target.
module exc_redirect_ctrl #(
  parameter int  MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exc_valid,
  input  logic [31:0]   exc_target,
  input  logic          exc_is_eret,
  input  logic          inst_req_fire,
  input  logic          inst_data_ok,
  input  logic          data_req_fire,
  input  logic          data_data_ok,
  input  logic          fetch_ready,
  output logic          flush_if,
  output logic          flush_id,
  output logic          flush_ex,
  output logic          flush_mem,
  output logic          block_mem_req,
  output logic          discard_resp,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          redirect_eret,
  output logic          busy,
  output logic [CW-1:0] inst_outstanding,
  output logic          protocol_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] inst_cnt_q, inst_cnt_d;
  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          eret_q, eret_d;
  logic          err_q, err_d;
  logic          flush_if_q, flush_stg_q, redir_q;
  logic          exc_err;
  logic [CW:0]   inst_step, data_step;

  // Saturating outstanding counter; MSB of the result flags an over/underflow.
  function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cnt,
                                           input logic inc, input logic dec);
    logic [CW:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CW'(MAX_OUTSTANDING)) r[CW] = 1'b1;
      else                             r[CW-1:0] = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) r[CW] = 1'b1;
      else           r[CW-1:0] = cnt - 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    inst_step  = cnt_step(inst_cnt_q, inst_req_fire, inst_data_ok);
    data_step  = cnt_step(data_cnt_q, data_req_fire, data_data_ok);
    inst_cnt_d = inst_step[CW-1:0];
    data_cnt_d = data_step[CW-1:0];
    state_d    = state_q;
    pc_d       = pc_q;
    eret_d     = eret_q;
    exc_err    = exc_valid && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          pc_d    = exc_target;
          eret_d  = exc_is_eret;
          state_d = FLUSH;
        end
      end
      FLUSH:    state_d = DRAIN;
      DRAIN: begin
        if ((inst_cnt_q == '0) && (data_cnt_q == '0) && fetch_ready)
          state_d = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    err_d = err_q | exc_err | inst_step[CW] | data_step[CW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      inst_cnt_q  <= '0;
      data_cnt_q  <= '0;
      pc_q        <= '0;
      eret_q      <= 1'b0;
      err_q       <= 1'b0;
      flush_if_q  <= 1'b0;
      flush_stg_q <= 1'b0;
      redir_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_cnt_q  <= inst_cnt_d;
      data_cnt_q  <= data_cnt_d;
      pc_q        <= pc_d;
      eret_q      <= eret_d;
      err_q       <= err_d;
      flush_if_q  <= (state_d != IDLE);
      flush_stg_q <= (state_d == FLUSH);
      redir_q     <= (state_d == REDIRECT);
    end
  end

  assign flush_if         = flush_if_q;
  assign flush_id         = flush_stg_q;
  assign flush_ex         = flush_stg_q;
  assign flush_mem        = flush_stg_q;
  assign redirect_valid   = redir_q;
  assign block_mem_req    = (state_q != IDLE);
  assign busy             = (state_q != IDLE);
  // Responses in the exc_valid cycle pass through; IF is squashed next cycle.
  assign discard_resp     = inst_data_ok && ((state_q == FLUSH) || (state_q == DRAIN));
  assign redirect_pc      = pc_q;
  assign redirect_eret    = eret_q;
  assign inst_outstanding = inst_cnt_q;
  assign protocol_err     = err_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: cycle-level reference model checked on
// every negedge, plus literal expectations taken from hand-worked timelines.
module tb_exc_redirect_ctrl;

  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          exc_valid, exc_is_eret;
  logic [31:0]   exc_target;
  logic          inst_req_fire, inst_data_ok, data_req_fire, data_data_ok, fetch_ready;
  logic          flush_if, flush_id, flush_ex, flush_mem, block_mem_req, discard_resp;
  logic          redirect_valid, redirect_eret, busy, protocol_err;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] inst_outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  exc_redirect_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_target(exc_target), .exc_is_eret(exc_is_eret),
    .inst_req_fire(inst_req_fire), .inst_data_ok(inst_data_ok),
    .data_req_fire(data_req_fire), .data_data_ok(data_data_ok),
    .fetch_ready(fetch_ready),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .block_mem_req(block_mem_req), .discard_resp(discard_resp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_eret(redirect_eret), .busy(busy),
    .inst_outstanding(inst_outstanding), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is "active" from the cycle after acceptance;
  // age 1 is the flush cycle, later cycles drain until the redirect cycle.
  bit          chk_en = 1'b0;
  int          m_icnt, m_dcnt, m_age;
  bit          m_active, m_redir, m_err, m_eret;
  logic [31:0] m_pc;

  function automatic int sat_cnt(input int c, input bit inc, input bit dec, inout bit err);
    if (inc && !dec) begin
      if (c == MAXO) err = 1'b1; else c = c + 1;
    end else if (dec && !inc) begin
      if (c == 0) err = 1'b1; else c = c - 1;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    bit e_stage;
    int ni, nd;
    if (chk_en) begin
      e_stage = m_active && (m_age == 1);
      chk("flush_if",       {31'd0, flush_if},       {31'd0, m_active});
      chk("flush_id",       {31'd0, flush_id},       {31'd0, e_stage});
      chk("flush_ex",       {31'd0, flush_ex},       {31'd0, e_stage});
      chk("flush_mem",      {31'd0, flush_mem},      {31'd0, e_stage});
      chk("block_mem_req",  {31'd0, block_mem_req},  {31'd0, m_active});
      chk("busy",           {31'd0, busy},           {31'd0, m_active});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
      chk("discard_resp",   {31'd0, discard_resp},
          {31'd0, inst_data_ok && m_active && !m_redir});
      chk("inst_outstanding", 32'(inst_outstanding), 32'(m_icnt));
      chk("protocol_err",   {31'd0, protocol_err},   {31'd0, m_err});
      chk("redirect_pc",    redirect_pc,             m_pc);
      chk("redirect_eret",  {31'd0, redirect_eret},  {31'd0, m_eret});
    end
    if (reset) begin
      m_icnt = 0; m_dcnt = 0; m_age = 0; m_active = 0; m_redir = 0;
      m_err = 0; m_eret = 0; m_pc = '0; chk_en = 1'b1;
    end else begin
      ni = sat_cnt(m_icnt, inst_req_fire, inst_data_ok, m_err);
      nd = sat_cnt(m_dcnt, data_req_fire, data_data_ok, m_err);
      if (!m_active) begin
        if (exc_valid) begin
          m_active = 1; m_age = 1; m_pc = exc_target; m_eret = exc_is_eret;
        end
      end else begin
        if (exc_valid) m_err = 1;
        if (m_redir) begin
          m_active = 0; m_redir = 0; m_age = 0;
        end else begin
          if (m_age >= 2 && m_icnt == 0 && m_dcnt == 0 && fetch_ready) m_redir = 1;
          m_age++;
        end
      end
      m_icnt = ni; m_dcnt = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exc_valid = 0; exc_is_eret = 0; inst_req_fire = 0; inst_data_ok = 0;
    data_req_fire = 0; data_data_ok = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; exc_target = '0; fetch_ready = 1; clr();
    step();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'h0);
    chk("rst inst_outstanding", 32'(inst_outstanding), 32'd0);
    chk("rst protocol_err", {31'd0, protocol_err}, 32'd0);
    step(); reset = 0;

    // Minimum-latency exception
    exc_valid = 1; exc_target = 32'hBFC00380;
    step(); exc_valid = 0;
    chk("t1 flush_id T+1", {31'd0, flush_id}, 32'd1);
    chk("t1 flush_if T+1", {31'd0, flush_if}, 32'd1);
    step();
    chk("t1 flush_mem T+2", {31'd0, flush_mem}, 32'd0);
    chk("t1 flush_if T+2", {31'd0, flush_if}, 32'd1);
    step();
    chk("t1 redirect_valid T+3", {31'd0, redirect_valid}, 32'd1);
    chk("t1 redirect_pc T+3", redirect_pc, 32'hBFC00380);
    step();
    chk("t1 busy T+4", {31'd0, busy}, 32'd0);

    // Two outstanding instruction fetches drained as stale responses
    inst_req_fire = 1; step(); step(); inst_req_fire = 0;
    chk("t2 inst_outstanding", 32'(inst_outstanding), 32'd2);
    exc_valid = 1; exc_target = 32'hBFC00380;
    step(); exc_valid = 0;
    step(); step();
    inst_data_ok = 1; #1;
    chk("t2 discard T+3", {31'd0, discard_resp}, 32'd1);
    step(); inst_data_ok = 0;
    chk("t2 inst_outstanding T+4", 32'(inst_outstanding), 32'd1);
    step(); inst_data_ok = 1; #1;
    chk("t2 discard T+5", {31'd0, discard_resp}, 32'd1);
    step(); inst_data_ok = 0;
    chk("t2 inst_outstanding T+6", 32'(inst_outstanding), 32'd0);
    chk("t2 redirect_valid T+6", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("t2 redirect_valid T+7", {31'd0, redirect_valid}, 32'd1);
    step();

    // Data drain with fetch_ready held low
    data_req_fire = 1; step(); data_req_fire = 0;
    fetch_ready = 0; exc_valid = 1;
    step(); exc_valid = 0;
    chk("t3 block T+1", {31'd0, block_mem_req}, 32'd1);
    step(); step(); step();
    data_data_ok = 1; #1;
    chk("t3 data not discarded", {31'd0, discard_resp}, 32'd0);
    step(); data_data_ok = 0;
    step(); fetch_ready = 1;
    chk("t3 redirect_valid T+6", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("t3 redirect_valid T+7", {31'd0, redirect_valid}, 32'd1);
    chk("t3 block T+7", {31'd0, block_mem_req}, 32'd1);
    step();
    chk("t3 block T+8", {31'd0, block_mem_req}, 32'd0);

    // ERET with a second exc_valid while busy
    exc_valid = 1; exc_is_eret = 1; exc_target = 32'h80001234;
    step(); clr(); step();
    exc_valid = 1; exc_target = 32'hBFC00380;
    step(); clr();
    chk("t4 redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t4 redirect_pc", redirect_pc, 32'h80001234);
    chk("t4 redirect_eret", {31'd0, redirect_eret}, 32'd1);
    chk("t4 protocol_err", {31'd0, protocol_err}, 32'd1);
    step();

    // exc_valid during the redirect cycle is ignored and flagged
    do_reset();
    exc_valid = 1; exc_target = 32'h00000040;
    step(); exc_valid = 0; step(); step();
    exc_valid = 1; exc_target = 32'h00000080;
    step(); exc_valid = 0;
    chk("t5 busy after ignored", {31'd0, busy}, 32'd0);
    chk("t5 protocol_err", {31'd0, protocol_err}, 32'd1);
    chk("t5 redirect_pc", redirect_pc, 32'h00000040);

    // Counter saturation
    do_reset();
    inst_req_fire = 1;
    repeat (4) step();
    chk("t6 inst at max", 32'(inst_outstanding), 32'd4);
    chk("t6 err before overflow", {31'd0, protocol_err}, 32'd0);
    step(); inst_req_fire = 0;
    chk("t6 inst saturated", 32'(inst_outstanding), 32'd4);
    chk("t6 err overflow", {31'd0, protocol_err}, 32'd1);
    do_reset();
    data_data_ok = 1; step(); data_data_ok = 0;
    chk("t6 err underflow", {31'd0, protocol_err}, 32'd1);
    exc_valid = 1; step(); exc_valid = 0; step(); step();
    chk("t6 data count stayed 0", {31'd0, redirect_valid}, 32'd1);
    step();

    // Fetch issued during DRAIN is counted without error
    do_reset();
    fetch_ready = 0; exc_valid = 1; exc_target = 32'h1000;
    step(); exc_valid = 0; step();
    inst_req_fire = 1; step(); inst_req_fire = 0;
    fetch_ready = 1; inst_data_ok = 1; #1;
    chk("t7 discard", {31'd0, discard_resp}, 32'd1);
    step(); inst_data_ok = 0; step();
    chk("t7 redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t7 protocol_err", {31'd0, protocol_err}, 32'd0);
    step();

    // Reset while draining aborts the redirect
    inst_req_fire = 1; step(); inst_req_fire = 0;
    exc_valid = 1; step(); exc_valid = 0; step();
    reset = 1; step(); reset = 0;
    chk("t8 busy", {31'd0, busy}, 32'd0);
    chk("t8 flush_if", {31'd0, flush_if}, 32'd0);
    chk("t8 inst_outstanding", 32'(inst_outstanding), 32'd0);
    chk("t8 redirect_pc", redirect_pc, 32'h0);
    step();
    chk("t8 no redirect", {31'd0, redirect_valid}, 32'd0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
